moving_sum_n: RTL and testbench

Parametrised moving-window accumulator over the last DEPTH signed samples, producing both the exact window sum and its floor average every cycle a sample is accepted. This is the generalised successor to the fixed three-tap sum stage and sits in the same sample-processing datapath. It adds the following over that stage:
- configurable width and depth;
- a valid qualifier;
- a window-full flag;
- a synchronous clear.

---
 rtl/moving_sum_pkg.sv | 33 +++
 rtl/sample_ring.sv | 43 ++++
 rtl/moving_sum_n.sv | 96 +++++++++
 tb/tb_moving_sum_n.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/moving_sum_pkg.sv
// Shared helpers for the moving-window accumulator: width derivation and
// parameter legality.
package moving_sum_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_DEPTH  = 4;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((32'd1 << res) < value) begin
      res = res + 1;
    end
    return res;
  endfunction

  function automatic bit is_pow2(input int unsigned value);
    return (value != 0) && ((value & (value - 1)) == 0);
  endfunction

  function automatic int unsigned ptr_width(input int unsigned depth);
    return clog2(depth);
  endfunction

  // The sum of DEPTH samples needs exactly log2(DEPTH) guard bits.
  function automatic int unsigned sum_width(input int unsigned data_w, input int unsigned depth);
    return data_w + clog2(depth);
  endfunction

  localparam int unsigned SUM_W = sum_width(DEF_DATA_W, DEF_DEPTH);
  localparam int unsigned PTR_W = ptr_width(DEF_DEPTH);

endpackage

// File: rtl/sample_ring.sv
// DEPTH-entry sample ring; the read port shows the entry about to be
// overwritten, i.e. the oldest sample in the window.
module sample_ring
  import moving_sum_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] old_data
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wp_q;
  logic              wrap;

  assign wrap     = (wp_q == PTR_W'(DEPTH - 1));
  assign old_data = mem_q[wp_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clear) begin
      wp_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wp_q] <= wr_data;
      wp_q        <= wrap ? '0 : wp_q + 1'b1;
    end
  end

endmodule

// File: rtl/moving_sum_n.sv
// Moving-window sum and floor average over the last DEPTH signed samples,
// updated once per accepted sample with one cycle of latency.
module moving_sum_n
  import moving_sum_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     in_valid,
  input  logic        [DATA_W-1:0]                 num,
  input  logic                                     clear,
  output logic signed [DATA_W+clog2(DEPTH)-1:0]    sum,
  output logic signed [DATA_W-1:0]                 avg,
  output logic                                     out_valid,
  output logic                                     full
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam int unsigned SUM_W = sum_width(DATA_W, DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  if (!is_pow2(DEPTH) || DEPTH < 2 || DEPTH > 256) begin : gen_depth_check
    $error("moving_sum_n: DEPTH must be a power of two in 2..256");
  end
  if (DATA_W < 2) begin : gen_width_check
    $error("moving_sum_n: DATA_W must be at least 2");
  end

  logic                    accept;
  logic [DATA_W-1:0]       old_data;
  logic signed [SUM_W-1:0] num_ext;
  logic signed [SUM_W-1:0] old_ext;
  logic signed [SUM_W-1:0] sum_d, sum_q;
  logic signed [DATA_W-1:0] avg_d, avg_q;
  logic [CNT_W-1:0]        cnt_d, cnt_q;
  logic                    full_d, full_q;
  logic                    out_valid_q;

  // clear wins over a coincident sample, which is dropped.
  assign accept = in_valid & ~clear;

  sample_ring #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ring (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .wr_en    (accept),
    .wr_data  (num),
    .old_data (old_data)
  );

  assign num_ext = {{(SUM_W - DATA_W){num[DATA_W-1]}}, num};
  assign old_ext = {{(SUM_W - DATA_W){old_data[DATA_W-1]}}, old_data};

  always_comb begin
    sum_d  = sum_q + num_ext - old_ext;
    // Arithmetic shift by log2(DEPTH) then truncation is exactly this slice.
    avg_d  = sum_d[SUM_W-1:PTR_W];
    cnt_d  = (cnt_q == CNT_W'(DEPTH)) ? cnt_q : cnt_q + 1'b1;
    full_d = (cnt_d == CNT_W'(DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q       <= '0;
      avg_q       <= '0;
      cnt_q       <= '0;
      full_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (clear) begin
      sum_q       <= '0;
      avg_q       <= '0;
      cnt_q       <= '0;
      full_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= accept;
      if (accept) begin
        sum_q  <= sum_d;
        avg_q  <= avg_d;
        cnt_q  <= cnt_d;
        full_q <= full_d;
      end
    end
  end

  assign sum       = sum_q;
  assign avg       = avg_q;
  assign out_valid = out_valid_q;
  assign full      = full_q;

endmodule

// File: tb/tb_moving_sum_n.sv
// Self-checking bench for moving_sum_n: vector table, scoreboard against a
// window model, async reset and a DEPTH=8 instance.
module tb_moving_sum_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               in_valid, clear;
  logic signed [7:0]  num;
  logic signed [9:0]  sum;
  logic signed [7:0]  avg;
  logic               out_valid, full;

  logic               in_valid2, clear2;
  logic signed [11:0] num2;
  logic signed [14:0] sum2;
  logic signed [11:0] avg2;
  logic               out_valid2, full2;

  moving_sum_n #(.DATA_W(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .num(num), .clear(clear),
    .sum(sum), .avg(avg), .out_valid(out_valid), .full(full)
  );

  moving_sum_n #(.DATA_W(12), .DEPTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .num(num2), .clear(clear2),
    .sum(sum2), .avg(avg2), .out_valid(out_valid2), .full(full2)
  );

  typedef struct {
    int v; int c; int num; int sum; int avg; int full; int ov;
  } vec_t;

  typedef struct {
    int sum; int avg;
  } exp_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs[$];
  exp_t sbq[$];
  int   win[4];
  int   wptr;
  int   mcnt;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int floor_div4(input int s);
    if (s >= 0) return s / 4;
    return -((-s + 3) / 4);
  endfunction

  function automatic int model_sum();
    int s = 0;
    for (int i = 0; i < 4; i++) s += win[i];
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) win[i] = 0;
    wptr = 0;
    mcnt = 0;
    sbq.delete();
  endtask

  task automatic model_step(input bit v, input bit c, input int n);
    int s;
    if (c) begin
      model_reset();
    end else if (v) begin
      win[wptr] = n;
      wptr = (wptr + 1) % 4;
      if (mcnt < 4) mcnt++;
      s = model_sum();
      sbq.push_back('{sum: s, avg: floor_div4(s)});
    end
  endtask

  // One clock of stimulus on the DEPTH=4 instance, scoreboarded after the edge.
  task automatic cycle(input bit v, input bit c, input int n);
    exp_t e;
    @(negedge clk);
    in_valid = v;
    clear    = c;
    num      = 8'(n);
    model_step(v, c, n);
    @(posedge clk);
    #1;
    check("ov_model", int'(out_valid), int'(v & ~c));
    check("full_model", int'(full), int'(mcnt == 4));
    if (out_valid) begin
      if (sbq.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        e = sbq.pop_front();
        check("sb_sum", int'(sum), e.sum);
        check("sb_avg", int'(avg), e.avg);
      end
    end
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic cycle8(input int n);
    @(negedge clk);
    in_valid2 = 1'b1;
    num2      = 12'(n);
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; clear = 1'b0; num = '0;
    in_valid2 = 1'b0; clear2 = 1'b0; num2 = '0;
    model_reset();
    #12;
    check("rst_sum", int'(sum), 0);
    check("rst_avg", int'(avg), 0);
    check("rst_ov", int'(out_valid), 0);
    check("rst_full", int'(full), 0);
    @(negedge clk);
    rst = 1'b0;

    // v, c, num, sum, avg, full, out_valid
    vecs.push_back('{1, 0, 2,    2,    0,    0, 1});
    vecs.push_back('{1, 0, 1,    3,    0,    0, 1});
    vecs.push_back('{1, 0, -1,   2,    0,    0, 1});
    vecs.push_back('{1, 0, -8,   -6,   -2,   1, 1});
    vecs.push_back('{1, 0, 5,    -3,   -1,   1, 1});
    vecs.push_back('{0, 1, 0,    0,    0,    0, 0});
    vecs.push_back('{1, 0, -128, -128, -32,  0, 1});
    vecs.push_back('{1, 0, -128, -256, -64,  0, 1});
    vecs.push_back('{1, 0, -128, -384, -96,  0, 1});
    vecs.push_back('{1, 0, -128, -512, -128, 1, 1});
    vecs.push_back('{1, 0, 127,  -257, -65,  1, 1});
    vecs.push_back('{1, 0, 127,  -2,   -1,   1, 1});
    vecs.push_back('{1, 0, 127,  253,  63,   1, 1});
    vecs.push_back('{1, 0, 127,  508,  127,  1, 1});
    vecs.push_back('{0, 1, 0,    0,    0,    0, 0});
    vecs.push_back('{1, 0, 4,    4,    1,    0, 1});
    vecs.push_back('{0, 0, 99,   4,    1,    0, 0});
    vecs.push_back('{0, 0, 99,   4,    1,    0, 0});
    vecs.push_back('{0, 0, 99,   4,    1,    0, 0});
    vecs.push_back('{1, 0, 4,    8,    2,    0, 1});
    vecs.push_back('{1, 0, 16,   24,   6,    0, 1});
    vecs.push_back('{1, 0, 16,   40,   10,   1, 1});
    vecs.push_back('{1, 1, 9,    0,    0,    0, 0});
    vecs.push_back('{1, 0, 3,    3,    0,    0, 1});
    vecs.push_back('{0, 0, 77,   3,    0,    0, 0});

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].v != 0, vecs[i].c != 0, vecs[i].num);
      check($sformatf("vec%0d_sum", i), int'(sum), vecs[i].sum);
      check($sformatf("vec%0d_avg", i), int'(avg), vecs[i].avg);
      check($sformatf("vec%0d_full", i), int'(full), vecs[i].full);
      check($sformatf("vec%0d_ov", i), int'(out_valid), vecs[i].ov);
    end

    // Asynchronous reset between edges, mid-stream.
    cycle(1'b1, 1'b0, 10);
    cycle(1'b1, 1'b0, 20);
    check("pre_rst_sum", int'(sum), 33);
    #2;
    rst = 1'b1;
    #1;
    check("arst_sum", int'(sum), 0);
    check("arst_avg", int'(avg), 0);
    check("arst_ov", int'(out_valid), 0);
    check("arst_full", int'(full), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 1'b0, 7);
    check("post_rst_sum", int'(sum), 7);
    check("post_rst_avg", int'(avg), 1);

    // Random stream against the window model.
    for (int i = 0; i < 80; i++) begin
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
            int'($urandom_range(0, 255)) - 128);
    end

    // DEPTH=8, DATA_W=12 instance.
    for (int i = 1; i <= 8; i++) begin
      cycle8(-1);
      if (i == 7) begin
        check("d8_sum7", int'(sum2), -7);
        check("d8_full7", int'(full2), 0);
      end
    end
    check("d8_sum8", int'(sum2), -8);
    check("d8_avg8", int'(avg2), -1);
    check("d8_full8", int'(full2), 1);
    check("d8_ov8", int'(out_valid2), 1);
    cycle8(-1);
    check("d8_sum9", int'(sum2), -8);
    check("d8_avg9", int'(avg2), -1);
    check("d8_full9", int'(full2), 1);
    @(posedge clk);
    #1;
    check("d8_idle_ov", int'(out_valid2), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
